// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared encodings and constants for the iterative divider
package div_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    // Most negative two's-complement values; the top XLEN bits of the 64-bit
    // constant give the full-width value for either supported XLEN.
    localparam logic [63:0] MOST_NEG_64 = 64'h8000_0000_0000_0000;
    localparam logic [31:0] MOST_NEG_32 = 32'h8000_0000;

endpackage

// File: rtl/div_operand_prep.sv
// rtl/div_operand_prep.sv - operand extension, magnitudes and one-cycle special results
module div_operand_prep
    import div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] a_mag,
    output logic [XLEN-1:0] b_mag,
    output logic            a_neg,
    output logic            b_neg,
    output logic            special,
    output logic [XLEN-1:0] special_result
);

    localparam logic [XLEN-1:0] MIN_FULL = MOST_NEG_64[63 -: XLEN];
    localparam logic [XLEN-1:0] MIN_WORD = XLEN'($signed(MOST_NEG_32));

    logic            is_signed;
    logic            is_rem;
    logic [XLEN-1:0] a_prep;
    logic [XLEN-1:0] b_prep;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] sel;

    // Extend operands to the effective width, then derive signs, magnitudes and specials
    always_comb begin
        is_signed = (op == OP_DIV) || (op == OP_REM);
        is_rem    = (op == OP_REM) || (op == OP_REMU);
        if (word) begin
            a_prep = is_signed ? XLEN'($signed(a[31:0])) : XLEN'(a[31:0]);
            b_prep = is_signed ? XLEN'($signed(b[31:0])) : XLEN'(b[31:0]);
        end else begin
            a_prep = a;
            b_prep = b;
        end
        a_neg    = is_signed & a_prep[XLEN-1];
        b_neg    = is_signed & b_prep[XLEN-1];
        a_mag    = a_neg ? -a_prep : a_prep;
        b_mag    = b_neg ? -b_prep : b_prep;
        div_zero = (b_prep == '0);
        overflow = is_signed && (a_prep == (word ? MIN_WORD : MIN_FULL)) && (b_prep == '1);
        special  = div_zero | overflow;
        if (div_zero) begin
            sel = is_rem ? a_prep : '1;
        end else begin
            sel = is_rem ? '0 : a_prep;
        end
        special_result = word ? XLEN'($signed(sel[31:0])) : sel;
    end

endmodule

// File: rtl/div_iter_unit.sv
// rtl/div_iter_unit.sv - iterative restoring divider for the M-extension divide/remainder ops
module div_iter_unit
    import div_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int WORD_OPS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);

    localparam int   CNT_W   = $clog2(XLEN);
    localparam logic WORD_EN = (WORD_OPS != 0) && (XLEN == 64);

    div_state_t      state;
    div_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] b_mag_q;
    logic [1:0]      op_q;
    logic            word_q;
    logic            a_neg_q;
    logic            b_neg_q;

    logic            word_eff;
    logic            accept;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            a_neg;
    logic            b_neg;
    logic            special;
    logic [XLEN-1:0] special_result;

    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic            ge;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] fix_sel;
    logic [XLEN-1:0] fix_result;

    assign word_eff = in_word & WORD_EN;
    assign accept   = in_valid & in_ready & ~flush;

    div_operand_prep #(.XLEN(XLEN)) u_prep (
        .op             (in_op),
        .word           (word_eff),
        .a              (in_a),
        .b              (in_b),
        .a_mag          (a_mag),
        .b_mag          (b_mag),
        .a_neg          (a_neg),
        .b_neg          (b_neg),
        .special        (special),
        .special_result (special_result)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; flush overrides every other request
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept) state_nxt = special ? ST_DONE : ST_CALC;
                ST_CALC: if (cnt == '0) state_nxt = ST_FIX;
                ST_FIX:  state_nxt = ST_DONE;
                ST_DONE: if (out_valid && out_ready) state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Unregistered status outputs decoded from the state register
    always_comb begin
        in_ready = (state == ST_IDLE) && !rst;
        busy     = (state != ST_IDLE);
    end

    // One restoring step plus the sign fix-up applied after the last step
    always_comb begin
        shifted    = {rem[XLEN-1:0], quo[XLEN-1]};
        ge         = ({rem, quo[XLEN-1]} >= {2'b00, b_mag_q});
        trial      = shifted - {1'b0, b_mag_q};
        quo_fix    = (a_neg_q ^ b_neg_q) ? -quo : quo;
        rem_fix    = a_neg_q ? -rem[XLEN-1:0] : rem[XLEN-1:0];
        fix_sel    = op_q[1] ? rem_fix : quo_fix;
        fix_result = word_q ? XLEN'($signed(fix_sel[31:0])) : fix_sel;
    end

    // Datapath: latch operands on accept, iterate in CALC, register the result
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            rem        <= '0;
            quo        <= '0;
            b_mag_q    <= '0;
            op_q       <= OP_DIV;
            word_q     <= 1'b0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            out_result <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= in_op;
                        word_q  <= word_eff;
                        a_neg_q <= a_neg;
                        b_neg_q <= b_neg;
                        b_mag_q <= b_mag;
                        rem     <= '0;
                        // Word magnitudes sit in the top half so 32 steps consume them
                        quo     <= word_eff ? (a_mag << (XLEN - 32)) : a_mag;
                        cnt     <= word_eff ? CNT_W'(31) : CNT_W'(XLEN - 1);
                        if (special) out_result <= special_result;
                    end
                end
                ST_CALC: begin
                    rem <= ge ? trial : shifted;
                    quo <= {quo[XLEN-2:0], ge};
                    cnt <= cnt - 1'b1;
                end
                ST_FIX:  out_result <= fix_result;
                default: ;
            endcase
        end
    end

    // out_valid follows DONE by one edge and drops on the handshake or a flush
    always_ff @(posedge clk) begin
        if (rst || flush) out_valid <= 1'b0;
        else              out_valid <= (state == ST_DONE) && !(out_valid && out_ready);
    end

endmodule

// File: tb/tb_div_iter_unit.sv
// tb/tb_div_iter_unit.sv - scoreboard bench for div_iter_unit against an arithmetic model
module tb_div_iter_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic        in_word = 1'b0;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_result;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit bp_rand = 1'b0;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    div_iter_unit #(.XLEN(64), .WORD_OPS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_word    (in_word),
        .in_a       (in_a),
        .in_b       (in_b),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RISC-V divide semantics from plain arithmetic
    function automatic logic [63:0] model(input logic [1:0] op, input logic word,
                                          input logic [63:0] a, input logic [63:0] b);
        logic        sgn;
        logic [31:0] q32, r32, s32;
        logic [63:0] q64, r64;
        int          sa32, sb32;
        longint      sa64, sb64;
        sgn = !op[0];
        if (word) begin
            sa32 = a[31:0];
            sb32 = b[31:0];
            if (b[31:0] == 32'd0) begin
                q32 = '1; r32 = a[31:0];
            end else if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
                q32 = a[31:0]; r32 = '0;
            end else if (sgn) begin
                q32 = sa32 / sb32; r32 = sa32 % sb32;
            end else begin
                q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0];
            end
            s32 = op[1] ? r32 : q32;
            return {{32{s32[31]}}, s32};
        end
        sa64 = a;
        sb64 = b;
        if (b == 64'd0) begin
            q64 = '1; r64 = a;
        end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q64 = a; r64 = '0;
        end else if (sgn) begin
            q64 = sa64 / sb64; r64 = sa64 % sb64;
        end else begin
            q64 = a / b; r64 = a % b;
        end
        return op[1] ? r64 : q64;
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic word,
                                      input logic [63:0] a, input logic [63:0] b);
        if (word)
            return (b[31:0] == 0) || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == '1);
        return (b == 0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    // Present a request; push the expected response at the accept edge when one is due
    task automatic issue(input logic [1:0] op, input logic word, input logic [63:0] a,
                         input logic [63:0] b, input bit expect_out, input logic [63:0] ref_res);
        exp_t e;
        int   n;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_word = word; in_a = a; in_b = b;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL issue_timeout: in_ready stayed 0, required 1");
        end else begin
            e.res = ref_res;
            e.lat = is_special(op, word, a, b) ? 1 : (word ? 34 : 66);
            e.acc = cyc + 1;
            if (expect_out) sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run(input logic [1:0] op, input logic word, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_res);
        chk("model_vs_table", model(op, word, a, b), exp_res);
        issue(op, word, a, b, 1'b1, model(op, word, a, b));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
    endtask

    // Monitor: pop on each new result, check value, latency and stability under backpressure
    logic        prev_v = 1'b0;
    logic [63:0] held = '0;
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && out_valid) begin
            if (!prev_v) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_out: result %h with nothing outstanding", out_result);
                end else begin
                    e = sb.pop_front();
                    chk("result", out_result, e.res);
                    chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                end
                held = out_result;
            end else begin
                chk("hold_stable", out_result, held);
            end
        end
        prev_v = out_valid && !rst;
    end

    initial forever begin
        @(negedge clk);
        if (bp_rand) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ra, rb, m1, mn;
        logic [1:0]  rop;
        logic        rw;
        int          n;
        m1 = '1;
        mn = 64'h8000_0000_0000_0000;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        run(2'b00, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        drain();
        run(2'b10, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        drain();
        run(2'b01, 1'b0, 64'd100, 64'd7, 64'd14);
        drain();
        run(2'b11, 1'b0, 64'd100, 64'd7, 64'd2);
        drain();
        run(2'b01, 1'b1, 64'hFFFF_FFFF, 64'h10, 64'h0000_0000_0FFF_FFFF);
        drain();
        run(2'b00, 1'b0, 64'd5, 64'd0, m1);
        drain();
        run(2'b10, 1'b1, 64'h0000_0001_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005);
        drain();
        run(2'b00, 1'b0, mn, m1, mn);
        drain();
        run(2'b10, 1'b0, mn, m1, 64'd0);
        drain();
        run(2'b00, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
        drain();

        // Backpressure: hold the result for five cycles
        out_ready = 1'b0;
        run(2'b01, 1'b0, 64'd1000, 64'd9, 64'd111);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid_held", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_after", 64'(in_ready), 64'd1);
        chk("bp_out_valid_after", 64'(out_valid), 64'd0);

        // Flush at CALC cycle 10, then reset in the middle of the next op
        issue(2'b00, 1'b0, 64'd12345, 64'd3, 1'b0, '0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        issue(2'b11, 1'b0, 64'd999, 64'd4, 1'b0, '0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        run(2'b01, 1'b0, 64'd100, 64'd7, 64'd14);
        drain();

        // Randomised traffic with random backpressure
        bp_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            rw  = 1'($urandom_range(0, 1));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = rw ? 64'h8000_0000 : mn; rb = m1; end
                2: rb = 64'($urandom_range(1, 20));
                3: rb = -64'($urandom_range(1, 20));
                4: ra = 64'($urandom_range(0, 50));
                default: ;
            endcase
            issue(rop, rw, ra, rb, 1'b1, model(rop, rw, ra, rb));
        end
        drain();
        bp_rand = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_iter_unit.md
# div_iter_unit

Parametrised iterative integer divider for the execute stage, successor to the fixed 64-bit multi-cycle divider. It implements all RISC-V M-extension divide/remainder ops (DIV, DIVU, REM, REMU and their W forms) on an XLEN-wide datapath. It uses valid/ready handshakes on both sides, shortens iteration count for word ops, resolves divide-by-zero and signed overflow in one cycle, and supports pipeline flush.

## Interface
- XLEN, 64: operand/result width; must be 32 or 64.
- WORD_OPS, 1: enables in_word (W ops); requires XLEN=64. When 0, in_word is ignored.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept; high only in IDLE and with rst low.
- in_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- in_word  in  1  W-op: use in_a[31:0]/in_b[31:0], result sign-extended from bit 31.
- in_a  in  XLEN  dividend.
- in_b  in  XLEN  divisor.
- flush  in  1  kill in-flight op; no result produced.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- out_result  out  XLEN  quotient or remainder per latched op.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: on in_valid & in_ready & ~flush, latch op, word flag and prepared operands.
  - Special case → DONE.
  - Otherwise → CALC, with counter = N−1 (N = 32 if word, else XLEN).
- Operand prep: word ops sign-extend (signed) or zero-extend (unsigned) from bit 31. Signed = op[0]==0.
- Special cases:
  - Divisor==0: quotient all ones, remainder = prepared dividend.
  - Signed overflow (dividend = most negative of the effective width, divisor = −1): quotient = dividend, remainder = 0.
- CALC: unsigned restoring division on magnitudes, one quotient bit per cycle.
  - Registers: rem (XLEN+1 bits) and quo (XLEN bits).
  - Word ops preload the magnitude into quo[XLEN-1:XLEN-32] so exactly 32 iterations complete.
  - Each cycle: trial = {rem[XLEN-1:0], quo[MSB]} − |b|. If trial ≥ 0 then rem ← trial, else rem ← shifted value. quo ← {quo<<1, trial≥0}.
  - Counter decrements; counter==0 → FIX.
- FIX (signed ops only):
  - Negate quotient when sign(a)≠sign(b).
  - Negate remainder when sign(a)=1.
  - Select quotient or remainder by op[1]; in word mode, sign-extend bit 31.
  - Register into out_result; → DONE.
- DONE: out_valid=1. On out_ready → IDLE. out_result stable while out_valid & ~out_ready.
- Flush: any state → IDLE on next edge; out_valid low next cycle. Flush has priority over in_valid and out_ready in the same cycle.
- Reset: state IDLE, counter 0, out_valid 0, out_result 0, busy 0, in_ready 0 while rst high.

## Timing
- Accept edge = edge where in_valid & in_ready sampled high.
- Normal op: out_valid rises N+2 edges after accept (66 for 64-bit, 34 for word).
- Special case: out_valid rises 1 edge after accept.
- Throughput: in_ready returns the cycle after the out handshake edge. No accept in the same cycle as a result is delivered.
- All outputs registered except in_ready and busy (decoded from the state register).
- rst or flush mid-CALC: partial state is discarded and the next op is computed correctly.

## Structure
- Package div_pkg: op encodings (DIV/DIVU/REM/REMU), state enum, helper constant for most-negative value per width.
- Sub-module div_operand_prep (combinational), instantiated once:
  - width/sign extension
  - zero/overflow detection
  - magnitude computation
  - special-case result

## Test plan
- XLEN=64 DIV a=−7 b=2 → 0xFFFF_FFFF_FFFF_FFFD at edge 66; REM same operands → 0xFFFF_FFFF_FFFF_FFFF.
- DIVU a=100 b=7 → 14; REMU → 2. DIVUW a=0xFFFF_FFFF b=0x10 → 0x0000_0000_0FFF_FFFF at edge 34.
- b=0: DIV a=5 → all ones; REMW a=0x0000_0001_8000_0005 → 0xFFFF_FFFF_8000_0005; out_valid at edge 1.
- Overflow: DIV a=0x8000_0000_0000_0000 b=−1 → a, REM → 0; DIVW a=0x8000_0000 b=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000.
- Backpressure: hold out_ready low 5 cycles after out_valid → result stable, in_ready 0. Raise out_ready → in_ready 1 next cycle.
- Flush at CALC cycle 10, then rst mid-CALC of next op → no out_valid either time. A following DIVU 100/7 returns 14.
